csa_tree_pipe: RTL and testbench
================================

Name: csa_tree_pipe

Overview:
- Parametrised, pipelined successor to the combinational 3:2 carry-save adder tree.
- Sums NUM_ELEMENTS operands and widens the result so it cannot overflow.
- Supports signed or unsigned operands, with a configurable pipeline-register spacing between carry-save levels.
- Uses a valid/ready handshake with full back-pressure. Sits between the feature MAC array and the downstream normalisation stage of the 3D face pipeline.

Parameters:
- NUM_ELEMENTS, 52, number of operands; legal range ≥2.
- IN_WIDTH, 32, width of each operand.
- OUT_WIDTH, IN_WIDTH+$clog2(NUM_ELEMENTS), result width; must be ≥ IN_WIDTH.
- SIGNED, 0, 1 = operands are two's complement and are sign-extended to OUT_WIDTH; 0 = zero-extended.
- REG_EVERY, 2, number of 3:2 levels between pipeline registers; legal range ≥1.
- TAG_WIDTH, 8, width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input operands are valid.
- in_ready  out  1  block can accept a new operand set this cycle.
- in_data  in  IN_WIDTH x NUM_ELEMENTS  unpacked operand array.
- in_tag  in  TAG_WIDTH  sideband tag; travels with the data unchanged.
- out_valid  out  1  out_sum and out_tag are valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  OUT_WIDTH  sum of all operands.
- out_tag  out  TAG_WIDTH  tag of the operand set that produced out_sum.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: all valid bits are 0, so out_valid = 0. out_sum = 0, out_tag = 0. in_ready is 1 as soon as rst deasserts.
- Extension: each operand is extended to OUT_WIDTH first, sign or zero per SIGNED. All arithmetic is modulo 2^OUT_WIDTH.
- Reduction level: each 3:2 level maps n rows to 2*floor(n/3) + n%3 rows.
  - Per full-adder group: sum = a^b^c; carry = maj(a,b,c) << 1, with LSB 0 and the MSB carry discarded.
  - Leftover rows (n%3) pass through unchanged at the highest indices of the level output.
- Level count: L = number of levels until 2 rows remain. N=52 → L=9 (52,35,24,16,11,8,6,4,3,2). N=3 → L=1. N=2 → L=0.
- Pipeline registers: one after every REG_EVERY levels, plus one after the last level if L is not a multiple of REG_EVERY. That gives S = ceil(L/REG_EVERY) carry-save stages.
- Final stage: a carry-propagate add of the 2 remaining rows, registered into out_sum. Total latency = S+1 cycles. N=52, REG_EVERY=2 → 6 cycles; N=2 → 1 cycle.
- Stage control: each stage has a valid bit and a tag register.
- Handshake and stall:
  - Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv. This is combinational from out_ready; accept the path.
  - When adv = 1, every stage loads from its predecessor, and stage 0 loads in_valid.
  - When adv = 0, all stages hold, including the data and tag of invalid stages.
  - A transfer occurs on in_valid & in_ready. Output is consumed on out_valid & out_ready.
- Throughput: one result per cycle when out_ready is held high.
- Bubbles: gaps in in_valid propagate as bubbles; with out_ready high they are not compressed.
- Output stability: while out_valid=1 and out_ready=0, out_sum and out_tag are held stable.
- Gating: data registers may load regardless of valid (no data gating is required). Valid bits must be exact.
- Reset mid-operation: all in-flight results are dropped immediately (asynchronous clear). No partial result ever appears on out_valid.
- Simultaneous drain and fill with the pipe full: when out_ready=1, a new input is accepted in the same cycle the output drains.

Decomposition:
- Package csa_tree_pkg holds constant functions:
  - csa_next(n): rows after one level.
  - csa_levels(n): L.
  - csa_rows_at(n,k): rows after k levels.
  - csa_latency(n,r): S+1.
- Sub-module csa_level(N_IN, W): purely combinational; reduces N_IN rows to csa_next(N_IN) rows.
- The top instantiates one csa_level per level via generate, inserting registers per REG_EVERY, followed by the final CPA register.

Test Plan:
- Unsigned, N=52, IN_WIDTH=32, all operands 32'hFFFFFFFF, out_ready=1 → after 6 cycles out_valid=1, out_sum = 52*(2^32-1) = 0x33_FFFFFFCC (38 bits), tag echoed.
- SIGNED=1, N=5, IN_WIDTH=8, operands {-128,-128,-128,-128,127} → out_sum = -385 (11-bit 0x67F), latency csa_latency(5,2) = 3.
- N=2, REG_EVERY=1, operands 3 and 4 → out_sum = 7 one cycle after acceptance.
- Back-to-back stream of 20 random sets with out_ready=1 → 20 consecutive results, in order, tags matching, matching the reference model.
- out_ready=0 while the pipe fills with 6 sets → in_ready drops once all 6 stages are valid, out_sum is held stable; releasing out_ready drains results in order with none lost or duplicated.
- rst asserted asynchronously mid-stream (between clock edges) → out_valid falls immediately. After release, a new set 1+1+1 (N=3) gives out_sum = 3 with no stale outputs.

Source files
------------

// File: rtl/csa_tree_pkg.sv
// csa_tree_pkg: constant functions describing the shape of the pipelined 3:2 carry-save tree
package csa_tree_pkg;
  function automatic int csa_next(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction
  function automatic int csa_rows_at(input int n, input int k);
    int r = n;
    for (int i = 0; i < k; i++) r = csa_next(r);
    return r;
  endfunction
  function automatic int csa_levels(input int n);
    int r = n;
    int l = 0;
    while (r > 2) begin
      r = csa_next(r);
      l++;
    end
    return l;
  endfunction
  function automatic int csa_latency(input int n, input int r);
    return (csa_levels(n) + r - 1) / r + 1;
  endfunction
endpackage

// File: rtl/csa_level.sv
// csa_level: one combinational 3:2 reduction level, leftovers pass through at the top indices
module csa_level
  import csa_tree_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int W = 8,
  localparam int N_OUT = csa_next(N_IN)
) (
  input  logic [W-1:0] in_rows  [N_IN],
  output logic [W-1:0] out_rows [N_OUT]
);
  localparam int G = N_IN / 3;
  genvar g;
  for (g = 0; g < G; g++) begin : g_fa
    assign out_rows[2*g] = in_rows[3*g] ^ in_rows[3*g+1] ^ in_rows[3*g+2];
    assign out_rows[2*g+1] = ((in_rows[3*g] & in_rows[3*g+1]) | (in_rows[3*g] & in_rows[3*g+2])
                            | (in_rows[3*g+1] & in_rows[3*g+2])) << 1;
  end
  for (g = 0; g < N_IN % 3; g++) begin : g_pass
    assign out_rows[2*G+g] = in_rows[3*G+g];
  end
endmodule

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined carry-save adder tree with valid/ready back-pressure and a sideband tag
module csa_tree_pipe
  import csa_tree_pkg::*;
#(
  parameter int NUM_ELEMENTS = 52,
  parameter int IN_WIDTH = 32,
  parameter int OUT_WIDTH = IN_WIDTH + $clog2(NUM_ELEMENTS),
  parameter int SIGNED = 0,
  parameter int REG_EVERY = 2,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data [NUM_ELEMENTS],
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_sum,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int L = csa_levels(NUM_ELEMENTS);
  localparam int S = csa_latency(NUM_ELEMENTS, REG_EVERY) - 1;
  logic                 adv;
  logic [S:0]           vld;
  logic [TAG_WIDTH-1:0] tag [S+1];
  logic [OUT_WIDTH-1:0] ext [NUM_ELEMENTS];
  logic [OUT_WIDTH-1:0] f0, f1;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  assign out_valid = vld[S];
  assign out_tag = tag[S];
  genvar i, k;
  for (i = 0; i < NUM_ELEMENTS; i++) begin : g_ext
    assign ext[i] = SIGNED != 0 ? OUT_WIDTH'($signed(in_data[i])) : OUT_WIDTH'(in_data[i]);
  end
  for (k = 0; k < L; k++) begin : g_lvl
    localparam int NI = csa_rows_at(NUM_ELEMENTS, k);
    localparam int NO = csa_next(NI);
    logic [OUT_WIDTH-1:0] d [NI];
    logic [OUT_WIDTH-1:0] q [NO];
    logic [OUT_WIDTH-1:0] o [NO];
    if (k == 0) begin : g_in
      assign d = ext;
    end else begin : g_in
      assign d = g_lvl[k-1].o;
    end
    csa_level #(.N_IN(NI), .W(OUT_WIDTH)) u_level (.in_rows(d), .out_rows(q));
    // a stage boundary every REG_EVERY levels, and always after the last level
    if ((k + 1) % REG_EVERY == 0 || k == L - 1) begin : g_reg
      always_ff @(posedge clk or posedge rst)
        if (rst) o <= '{default: '0};
        else if (adv) o <= q;
    end else begin : g_wire
      assign o = q;
    end
  end
  if (L == 0) begin : g_fin
    assign f0 = ext[0];
    assign f1 = ext[1];
  end else begin : g_fin
    assign f0 = g_lvl[L-1].o[0];
    assign f1 = g_lvl[L-1].o[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld <= '0;
      tag <= '{default: '0};
      out_sum <= '0;
    end else if (adv) begin
      vld <= (S + 1)'({vld, in_valid});
      tag[0] <= in_tag;
      for (int j = 1; j <= S; j++) tag[j] <= tag[j-1];
      out_sum <= f0 + f1;
    end
endmodule

// File: tb/tb_csa_tree_pipe.sv
// tb_csa_tree_pipe: randomized and directed checks of csa_tree_pipe against a queue-based sum model
module tb_csa_tree_pipe;
  import csa_tree_pkg::*;
  localparam int N = 52, IW = 32, OW = 38, TW = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic iv, ir, ov, ordy, took;
  logic [IW-1:0] din [N];
  logic [TW-1:0] tin, tout;
  logic [OW-1:0] sum;
  csa_tree_pipe u_main (.clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(din),
    .in_tag(tin), .out_valid(ov), .out_ready(ordy), .out_sum(sum), .out_tag(tout));

  logic s_iv, s_ir, s_ov;
  logic [7:0] s_din [5];
  logic [7:0] s_tout;
  logic [10:0] s_sum;
  csa_tree_pipe #(.NUM_ELEMENTS(5), .IN_WIDTH(8), .SIGNED(1)) u_sgn (.clk(clk), .rst(rst),
    .in_valid(s_iv), .in_ready(s_ir), .in_data(s_din), .in_tag(8'h5a), .out_valid(s_ov),
    .out_ready(1'b1), .out_sum(s_sum), .out_tag(s_tout));

  logic p_iv, p_ir, p_ov;
  logic [7:0] p_din [2];
  logic [7:0] p_tout;
  logic [8:0] p_sum;
  csa_tree_pipe #(.NUM_ELEMENTS(2), .IN_WIDTH(8), .REG_EVERY(1)) u_pair (.clk(clk), .rst(rst),
    .in_valid(p_iv), .in_ready(p_ir), .in_data(p_din), .in_tag(8'h3c), .out_valid(p_ov),
    .out_ready(1'b1), .out_sum(p_sum), .out_tag(p_tout));

  logic t_iv, t_ir, t_ov;
  logic [7:0] t_din [3];
  logic [7:0] t_tout;
  logic [9:0] t_sum;
  csa_tree_pipe #(.NUM_ELEMENTS(3), .IN_WIDTH(8)) u_trio (.clk(clk), .rst(rst),
    .in_valid(t_iv), .in_ready(t_ir), .in_data(t_din), .in_tag(8'h77), .out_valid(t_ov),
    .out_ready(1'b1), .out_sum(t_sum), .out_tag(t_tout));

  int n_vec = 0, n_err = 0, n_out = 0, n_acc = 0;
  typedef struct packed { logic [OW-1:0] s; logic [TW-1:0] t; } res_t;
  res_t q[$];
  res_t e;
  logic held = 0;
  logic [OW-1:0] h_sum;
  logic [TW-1:0] h_tag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [IW-1:0] d [N]);
    logic [OW-1:0] s = '0;
    foreach (d[i]) s += OW'(d[i]);
    return s;
  endfunction

  task automatic rand_main();
    foreach (din[i]) din[i] = $urandom;
    tin = 8'($urandom);
  endtask

  // scoreboard: expected results queued on acceptance, popped on consumption
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", ov, 1);
        chk("hold_sum", sum, h_sum);
        chk("hold_tag", tout, h_tag);
      end
      held = ov && !ordy;
      h_sum = sum;
      h_tag = tout;
      if (ov && ordy) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_output: got sum %0h with nothing in flight", sum);
        end else begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("tag", tout, e.t);
          n_out++;
        end
      end
      if (iv && ir) begin
        q.push_back('{model(din), tin});
        n_acc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    iv = 0; ordy = 1; tin = 0; took = 0;
    foreach (din[i]) din[i] = '0;
    s_iv = 0; p_iv = 0; t_iv = 0;
    foreach (s_din[i]) s_din[i] = '0;
    foreach (p_din[i]) p_din[i] = '0;
    foreach (t_din[i]) t_din[i] = '0;
    #2;
    chk("rst_out_valid", ov, 0);
    chk("rst_out_sum", sum, 0);
    chk("rst_out_tag", tout, 0);
    chk("rst_small_valid", {s_ov, p_ov, t_ov}, 0);
    @(posedge clk); #1 rst = 0;
    chk("in_ready_after_rst", ir, 1);

    foreach (din[i]) din[i] = '1;
    chk("model_all_ones", model(din), 38'h33FFFFFFCC);
    chk("latency_52_2", csa_latency(52, 2), 6);
    chk("latency_5_2", csa_latency(5, 2), 3);
    chk("latency_2_1", csa_latency(2, 1), 1);

    tin = 8'hA5; iv = 1;
    @(posedge clk); #1 iv = 0;
    for (int c = 1; c < 6; c++) begin
      chk("lat6_early", ov, 0);
      @(posedge clk); #1;
    end
    chk("lat6_valid", ov, 1);
    chk("all_ones_sum", sum, 38'h33FFFFFFCC);
    chk("all_ones_tag", tout, 8'hA5);

    for (int i = 0; i < 4; i++) s_din[i] = 8'h80;
    s_din[4] = 8'h7f; s_iv = 1;
    @(posedge clk); #1 s_iv = 0;
    for (int c = 1; c < 3; c++) begin
      chk("sgn_early", s_ov, 0);
      @(posedge clk); #1;
    end
    chk("sgn_valid", s_ov, 1);
    chk("sgn_sum", s_sum, 11'h67F);
    chk("sgn_tag", s_tout, 8'h5a);

    p_din[0] = 3; p_din[1] = 4; p_iv = 1;
    #1 chk("pair_early", p_ov, 0);
    @(posedge clk); #1 p_iv = 0;
    chk("pair_valid", p_ov, 1);
    chk("pair_sum", p_sum, 9'd7);
    chk("pair_tag", p_tout, 8'h3c);

    n0 = n_out;
    for (int c = 0; c < 20; c++) begin
      rand_main(); iv = 1;
      @(posedge clk); #1;
    end
    iv = 0;
    repeat (6) @(posedge clk);
    #1 chk("stream_count", n_out - n0, 20);

    for (int c = 0; c < 80; c++) begin
      if (!iv || took) begin
        rand_main();
        iv = ($urandom % 3) != 0;
      end
      ordy = ($urandom % 4) != 0;
      #1 took = iv && ir;
      @(posedge clk); #1;
    end
    iv = 0; ordy = 1;
    repeat (8) @(posedge clk);
    #1 chk("random_drained", q.size(), 0);

    ordy = 0; n0 = n_acc; took = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || took) rand_main();
      iv = 1;
      #1 took = iv && ir;
      @(posedge clk); #1;
    end
    chk("stall_accepts", n_acc - n0, 6);
    chk("stall_in_ready", ir, 0);
    chk("stall_out_valid", ov, 1);
    n0 = n_out; ordy = 1;
    #1 chk("fill_on_drain", ir, 1);
    @(posedge clk); #1 iv = 0;
    repeat (8) @(posedge clk);
    #1 chk("stall_drain_count", n_out - n0, 7);
    chk("stall_drained", q.size(), 0);

    foreach (t_din[i]) t_din[i] = 8'd5;
    for (int c = 0; c < 8; c++) begin
      rand_main(); iv = 1; t_iv = 1;
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", ov, 1);
    #2 rst = 1;
    #1 chk("rst_async_valid", ov, 0);
    chk("rst_async_sum", sum, 0);
    chk("rst_async_trio", t_ov, 0);
    iv = 0; t_iv = 0;
    @(posedge clk); #1 rst = 0;
    foreach (t_din[i]) t_din[i] = 8'd1;
    t_iv = 1;
    @(posedge clk); #1 t_iv = 0;
    chk("trio_early", t_ov, 0);
    @(posedge clk); #1;
    chk("trio_valid", t_ov, 1);
    chk("trio_sum", t_sum, 10'd3);
    @(posedge clk); #1;
    chk("trio_single", t_ov, 0);
    repeat (6) @(posedge clk);
    #1 chk("no_stale_main", ov, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
